// File: rtl/bank_seq_pkg.sv
// Shared types and defaults for the banked line-memory sequencer.
// Holds the FSM encoding and the terminal-count helper.
package bank_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int NUM_BANKS_D  = 8;
  localparam int BANK_DEPTH_D = 8192;
  localparam int WR_LAG_D     = 13;
  localparam int SEL_LAG_D    = 2;

  // Counter value at which a frame has fully drained.
  function automatic int term_cnt(
    input int nb,
    input int depth,
    input int lag
  );
    return nb * depth + lag;
  endfunction

endpackage

// File: rtl/bank_onehot_dec.sv
// Lagged bank decoder: maps a frame count to a one-hot bank.
// Also reports whether the lagged count is inside the frame.
module bank_onehot_dec
  import bank_seq_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_D,
  parameter int BANK_DEPTH = BANK_DEPTH_D,
  parameter int CNT_W      = 17,
  parameter int LAG        = 0,
  parameter int IW         = $clog2(NUM_BANKS)
) (
  input  logic [CNT_W-1:0]     cnt,
  input  logic                 en,
  output logic [NUM_BANKS-1:0] onehot,
  output logic [IW-1:0]        idx,
  output logic                 in_range,
  output logic                 past
);

  localparam int L = $clog2(BANK_DEPTH);
  localparam logic [CNT_W-1:0] LAG_C = CNT_W'(LAG);
  localparam logic [CNT_W-1:0] T_C =
    CNT_W'(NUM_BANKS * BANK_DEPTH);

  logic [CNT_W-1:0] off;

  generate
    if (LAG == 0) begin : g_nolag
      assign past = 1'b1;
    end else begin : g_lag
      assign past = (cnt >= LAG_C);
    end
  endgenerate

  assign off      = cnt - LAG_C;
  assign in_range = past && (off < T_C);
  assign idx      = IW'(off >> L);

  // Light exactly one bank while enabled and in range.
  always_comb begin
    onehot = '0;
    if (en && in_range) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bank_sequencer.sv
// Start/stall/done controller for the 8-bank window line memory.
// One frame counter drives read, write and output-mux decodes.
module bank_sequencer
  import bank_seq_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_D,
  parameter int BANK_DEPTH = BANK_DEPTH_D,
  parameter int WR_LAG     = WR_LAG_D,
  parameter int SEL_LAG    = SEL_LAG_D,
  parameter int CNT_W      = 17
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stall,
  output logic [NUM_BANKS-1:0]         rd_en,
  output logic [NUM_BANKS-1:0]         wr_en,
  output logic [$clog2(NUM_BANKS)-1:0] bank_sel,
  output logic                         pix_valid,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             frame_cnt
);

  localparam int IW = $clog2(NUM_BANKS);
  localparam logic [CNT_W-1:0] T_M1 =
    CNT_W'(NUM_BANKS * BANK_DEPTH - 1);
  localparam logic [CNT_W-1:0] END_M1 =
    CNT_W'(term_cnt(NUM_BANKS, BANK_DEPTH, WR_LAG) - 1);
  localparam logic [IW-1:0] LAST_B = IW'(NUM_BANKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run;
  logic             go;

  logic [IW-1:0]        rd_idx, wr_idx, sel_idx;
  logic                 rd_hit, wr_hit, sel_hit;
  logic                 rd_past, wr_past, sel_past;
  logic [NUM_BANKS-1:0] sel_oh;
  logic                 unused_ok;

  // State and frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: start only acts when not busy; stall freezes all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == T_M1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!stall) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == END_M1) state_d = DONE;
        end
      end
    endcase
  end

  assign run  = (state_q == RUN);
  assign busy = run | (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign go   = busy & ~stall;

  assign frame_cnt = cnt_q;

  bank_onehot_dec #(
    .NUM_BANKS  (NUM_BANKS),
    .BANK_DEPTH (BANK_DEPTH),
    .CNT_W      (CNT_W),
    .LAG        (0),
    .IW         (IW)
  ) u_rd (
    .cnt      (cnt_q),
    .en       (run & ~stall),
    .onehot   (rd_en),
    .idx      (rd_idx),
    .in_range (rd_hit),
    .past     (rd_past)
  );

  bank_onehot_dec #(
    .NUM_BANKS  (NUM_BANKS),
    .BANK_DEPTH (BANK_DEPTH),
    .CNT_W      (CNT_W),
    .LAG        (WR_LAG),
    .IW         (IW)
  ) u_wr (
    .cnt      (cnt_q),
    .en       (go),
    .onehot   (wr_en),
    .idx      (wr_idx),
    .in_range (wr_hit),
    .past     (wr_past)
  );

  bank_onehot_dec #(
    .NUM_BANKS  (NUM_BANKS),
    .BANK_DEPTH (BANK_DEPTH),
    .CNT_W      (CNT_W),
    .LAG        (SEL_LAG),
    .IW         (IW)
  ) u_sel (
    .cnt      (cnt_q),
    .en       (go),
    .onehot   (sel_oh),
    .idx      (sel_idx),
    .in_range (sel_hit),
    .past     (sel_past)
  );

  assign pix_valid = |sel_oh;

  assign bank_sel = !sel_past ? '0 :
                    sel_hit   ? sel_idx : LAST_B;

  assign unused_ok = ^{rd_idx, rd_hit, rd_past,
                       wr_idx, wr_hit, wr_past};

endmodule

// File: tb/tb_bank_sequencer.sv
// Bench for bank_sequencer: frame-level model plus directed checks.
// Runs with 4 banks of 16, write lag 3, select lag 2 (T=64).
module tb_bank_sequencer;

  localparam int NB = 4;
  localparam int D  = 16;
  localparam int WL = 3;
  localparam int SL = 2;
  localparam int CW = 8;
  localparam int T  = NB * D;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;

  logic [NB-1:0] rd_en, wr_en;
  logic [1:0]    bank_sel;
  logic          pix_valid, busy, done;
  logic [CW-1:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  int pv_total = 0;

  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_cnt  = 0;

  always #5 clk = ~clk;

  bank_sequencer #(
    .NUM_BANKS  (NB),
    .BANK_DEPTH (D),
    .WR_LAG     (WL),
    .SEL_LAG    (SL),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .bank_sel  (bank_sel),
    .pix_valid (pix_valid),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  // Frame model: busy for T+WL unstalled cycles, then done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_done <= 1'b0;
        m_cnt  <= 0;
      end
    end else if (!stall) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == T + WL) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end
  end

  // Running count of valid window strobes.
  always @(negedge clk) begin
    if (pix_valid === 1'b1) pv_total <= pv_total + 1;
  end

  function automatic logic [NB-1:0] oh(input int b);
    logic [NB-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic s, input logic st);
    @(posedge clk);
    #1;
    start = s;
    stall = st;
    #1;
  endtask

  // Per-cycle compare of every output against the model.
  initial begin
    logic [NB-1:0] e_rd, e_wr;
    int            e_sel;
    logic          e_pv;
    forever begin
      @(negedge clk);
      e_rd = '0;
      e_wr = '0;
      if (m_busy && !stall && m_cnt < T)
        e_rd = oh(m_cnt / D);
      if (m_busy && !stall && m_cnt >= WL && m_cnt - WL < T)
        e_wr = oh((m_cnt - WL) / D);
      if (m_cnt < SL) e_sel = 0;
      else e_sel = (m_cnt - SL) / D;
      if (e_sel > NB - 1) e_sel = NB - 1;
      e_pv = m_busy && !stall && m_cnt >= SL && m_cnt < T + SL;
      check("rd_en", 32'(rd_en), 32'(e_rd));
      check("wr_en", 32'(wr_en), 32'(e_wr));
      check("bank_sel", 32'(bank_sel), 32'(e_sel));
      check("pix_valid", 32'(pix_valid), 32'(e_pv));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      check("rd_onehot", 32'($countones(rd_en) <= 1), 32'd1);
      check("wr_onehot", 32'($countones(wr_en) <= 1), 32'd1);
    end
  end

  initial begin
    int busy_n;
    int pv0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_rd", 32'(rd_en), 32'd0);
    check("rst_wr", 32'(wr_en), 32'd0);
    check("rst_sel", 32'(bank_sel), 32'd0);
    check("rst_pv", 32'(pix_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);

    // Frame 1: no stalls.
    pv0 = pv_total;
    busy_n = 0;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, 1'b0);
      if (busy) busy_n++;
      if (i == 0) check("f1_rd0", 32'(rd_en), 32'h1);
      if (i == 15) check("f1_rd15", 32'(rd_en), 32'h1);
      if (i == 16) begin
        check("f1_rd16", 32'(rd_en), 32'h2);
        check("f1_wr16", 32'(wr_en), 32'h1);
      end
      if (i == 18) begin
        check("f1_sel18", 32'(bank_sel), 32'd1);
        check("f1_wr18", 32'(wr_en), 32'h1);
      end
      if (i == 19) check("f1_wr19", 32'(wr_en), 32'h2);
      if (i == 63) check("f1_rd63", 32'(rd_en), 32'h8);
      if (i == 64) check("f1_rd64", 32'(rd_en), 32'h0);
      if (i == 66) check("f1_wr66", 32'(wr_en), 32'h8);
      if (i == 67) begin
        check("f1_wr67", 32'(wr_en), 32'h0);
        check("f1_done67", 32'(done), 32'd1);
        check("f1_sel67", 32'(bank_sel), 32'd3);
      end
    end
    check("f1_busy_cycles", 32'(busy_n), 32'd67);
    check("f1_done", 32'(done), 32'd1);
    check("f1_pv_count", 32'(pv_total - pv0), 32'd64);

    // Frame 2: restart from DONE, start while busy, 5-cycle stall.
    pv0 = pv_total;
    busy_n = 0;
    cyc(1'b1, 1'b0);
    check("f2_done_pre", 32'(done), 32'd1);
    check("f2_busy_pre", 32'(busy), 32'd0);
    for (int j = 0; j < 80; j++) begin
      cyc(1'(j == 10), 1'(j >= 20 && j < 25));
      if (busy) busy_n++;
      if (j == 0) begin
        check("f2_done0", 32'(done), 32'd0);
        check("f2_busy0", 32'(busy), 32'd1);
        check("f2_cnt0", 32'(frame_cnt), 32'd0);
      end
      if (j == 10) check("f2_cnt10", 32'(frame_cnt), 32'd10);
      if (j == 11) check("f2_cnt11", 32'(frame_cnt), 32'd11);
      if (j >= 20 && j < 25) begin
        check("f2_stall_cnt", 32'(frame_cnt), 32'd20);
        check("f2_stall_rd", 32'(rd_en), 32'd0);
        check("f2_stall_wr", 32'(wr_en), 32'd0);
        check("f2_stall_pv", 32'(pix_valid), 32'd0);
        check("f2_stall_busy", 32'(busy), 32'd1);
      end
      if (j == 25) begin
        check("f2_cnt25", 32'(frame_cnt), 32'd20);
        check("f2_rd25", 32'(rd_en), 32'h2);
      end
      if (j == 26) check("f2_cnt26", 32'(frame_cnt), 32'd21);
    end
    check("f2_busy_cycles", 32'(busy_n), 32'd72);
    check("f2_done", 32'(done), 32'd1);
    check("f2_pv_count", 32'(pv_total - pv0), 32'd64);

    // Frame 3: asynchronous reset at cnt 30, then restart.
    cyc(1'b1, 1'b0);
    for (int i = 0; i <= 30; i++) cyc(1'b0, 1'b0);
    check("f3_cnt30", 32'(frame_cnt), 32'd30);
    check("f3_sel30", 32'(bank_sel), 32'd1);
    rst_n = 1'b0;
    #1;
    check("f3_rst_rd", 32'(rd_en), 32'd0);
    check("f3_rst_wr", 32'(wr_en), 32'd0);
    check("f3_rst_busy", 32'(busy), 32'd0);
    check("f3_rst_cnt", 32'(frame_cnt), 32'd0);
    check("f3_rst_sel", 32'(bank_sel), 32'd0);
    check("f3_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("f3_cnt0", 32'(frame_cnt), 32'd0);
    check("f3_rd0", 32'(rd_en), 32'h1);
    check("f3_busy0", 32'(busy), 32'd1);
    for (int k = 0; k < 100 && done !== 1'b1; k++)
      cyc(1'b0, 1'b0);
    check("f3_done", 32'(done), 32'd1);

    // Frames 4-5: random stall patterns.
    for (int f = 0; f < 2; f++) begin
      pv0 = pv_total;
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      for (int k = 0; k < 400 && done !== 1'b1; k++)
        cyc(1'b0, 1'($urandom_range(0, 3) == 0));
      stall = 1'b0;
      check("rnd_done", 32'(done), 32'd1);
      check("rnd_pv_count", 32'(pv_total - pv0), 32'd64);
    end

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
